router_fifo: RTL and testbench
==============================

Name: router_fifo

Overview:
- Output-port FIFO of the 1x3 router, one instance per destination.
- Sits directly downstream of router_reg: takes its registered dout byte stream (header, payload, parity) and buffers it for the destination reader.
- Tags each header byte on write so the read side can track packet boundaries.
- Returns data_out to 0 once a whole packet has been drained.

Parameters:
- WIDTH, 8, byte width of data path.
- DEPTH, 16, number of entries; power of two.
- AW, 4, pointer index width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- soft_rst  input  1  synchronous flush, from sync block read-timeout.
- we  input  1  write enable (FSM write_enb for this port).
- re  input  1  read enable from destination.
- lfd_state  input  1  marks the byte written this cycle as a header.
- data_in  input  WIDTH  byte from router_reg dout.
- data_out  output  WIDTH  registered read data.
- full  output  1  no free entries.
- empty  output  1  no stored entries.
- pkt_busy  output  1  high while the remaining-byte count is nonzero.

Behaviour:
- Storage: DEPTH entries of WIDTH+1 bits; bit WIDTH = header flag, written from lfd_state.
- Pointers: wr_ptr and rd_ptr, each AW+1 bits.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low AW bits equal.
  - Both flags are combinational from the pointers.
- Write: occurs when we && !full; stores {lfd_state, data_in}; wr_ptr++ with natural wrap.
- Read: occurs when re && !empty; data_out <= entry[WIDTH-1:0] on that edge (1-cycle latency); rd_ptr++.
- Blocked accesses:
  - Write while full is dropped; no pointer change.
  - Read while empty is ignored.
- Simultaneous re && we:
  - Both proceed when neither flag blocks.
  - When full, only the read proceeds.
  - When empty, only the write proceeds.
  - Flags are evaluated on pre-edge pointers.
- Packet counter cnt (7 bits):
  - On a read of a flagged entry: cnt <= entry[7:2] + 1 (payload length plus parity byte).
  - On a read of an unflagged entry with cnt != 0: cnt <= cnt - 1.
  - Header reload overrides any nonzero residual cnt (truncated prior packet is abandoned).
  - Payload length 0 gives cnt = 1.
  - pkt_busy = (cnt != 0).
- data_out update priority per cycle:
  - read occurring: load entry;
  - else cnt == 0: data_out <= 0;
  - else hold.
- soft_rst (synchronous, highest priority over we/re at an edge):
  - wr_ptr, rd_ptr, cnt, data_out cleared to 0.
  - All header flags cleared.
  - empty = 1, full = 0 next cycle.
- rst (asynchronous):
  - Same clearing as soft_rst, immediately on assertion.
  - Memory data bits need not be cleared; flags must be.
- Reset values: data_out = 0, full = 0, empty = 1, pkt_busy = 0.
- Reset mid-packet: all in-flight bytes are discarded; the first byte written after release is handled fresh.

Test Plan:
- Reset: assert rst with we=1 data_in=8'hAA -> data_out=0, empty=1, full=0, pkt_busy=0; no write retained after release.
- Single packet:
  - Write header 8'h1E (len 7, addr 2'b10, lfd_state=1), then 7 payload bytes and parity 8'h5C.
  - Read 9 times -> data_out equals the bytes in order, each one cycle after re.
  - pkt_busy drops after the parity read; data_out returns to 0 the following cycle.
- Full boundary:
  - 16 writes -> full=1 after the 16th.
  - 17th write with data 8'hFF is dropped.
  - One read then one write -> full=1 again; reads return the original 16 bytes, never 8'hFF.
- Wrap and concurrency: keep 4 entries occupied and issue re && we together for 40 cycles -> order preserved across pointer wrap; full/empty never assert.
- Soft reset mid-packet: after 3 of 9 bytes are read, pulse soft_rst -> empty=1, pkt_busy=0, data_out=0. A following packet with header 8'h04 (len 1) reads back header, payload and parity, then data_out returns to 0.
- Empty read: re=1 with empty=1 -> rd_ptr unchanged, data_out stays 0.

Source files
------------

// File: rtl/router_fifo.sv
`default_nettype none
// ============================================================================
// Module   : router_fifo
// Brief    : Per-destination output FIFO of the 1x3 router. Tags header bytes
//            and tracks the remaining bytes of the packet being drained.
// Revision : 1.0 - initial release
// ============================================================================
module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst,
    input  logic             we,
    input  logic             re,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             pkt_busy
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_hdr;
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [6:0]       r_cnt;
    logic [WIDTH-1:0] r_data_out;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_en;
    logic             w_rd_en;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_rd_hdr;
    logic [6:0]       w_reload;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr_en   = we && !w_full;
    assign w_rd_en   = re && !w_empty;
    assign w_rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign w_rd_hdr  = r_hdr[r_rd_ptr[AW-1:0]];
    // Header bits [7:2] carry the payload length; +1 accounts for parity.
    assign w_reload  = {1'b0, w_rd_data[7:2]} + 7'd1;

    // Data bits carry no reset; stale contents are unreachable once the
    // pointers and header flags are cleared.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_hdr      <= '0;
            r_cnt      <= '0;
            r_data_out <= '0;
        end else if (soft_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_hdr      <= '0;
            r_cnt      <= '0;
            r_data_out <= '0;
        end else begin
            if (w_wr_en) begin
                r_hdr[r_wr_ptr[AW-1:0]] <= lfd_state;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= w_rd_data;
                // A new header abandons whatever is left of a truncated packet.
                if (w_rd_hdr) begin
                    r_cnt <= w_reload;
                end else if (r_cnt != 7'd0) begin
                    r_cnt <= r_cnt - 7'd1;
                end
            end else if (r_cnt == 7'd0) begin
                r_data_out <= '0;
            end
        end
    end

    assign data_out = r_data_out;
    assign full     = w_full;
    assign empty    = w_empty;
    assign pkt_busy = (r_cnt != 7'd0);

endmodule
`default_nettype wire

// File: tb/tb_router_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_fifo
// Brief    : Directed self-checking bench for router_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_fifo;

    logic       clk;
    logic       rst;
    logic       soft_rst;
    logic       we;
    logic       re;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       pkt_busy;

    int n_checks = 0;
    int n_fail   = 0;

    router_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .soft_rst  (soft_rst),
        .we        (we),
        .re        (re),
        .lfd_state (lfd_state),
        .data_in   (data_in),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty),
        .pkt_busy  (pkt_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic hdr);
        we        = 1'b1;
        data_in   = d;
        lfd_state = hdr;
        step();
        we        = 1'b0;
        lfd_state = 1'b0;
    endtask

    logic [7:0] pkt [9];

    initial begin
        rst = 1'b1; soft_rst = 1'b0; we = 1'b1; re = 1'b0;
        lfd_state = 1'b0; data_in = 8'hAA;

        // Reset with a write attempt pending
        step(); step();
        check("rst_data_out", data_out, 8'h00);
        check("rst_empty", 8'(empty), 8'h01);
        check("rst_full", 8'(full), 8'h00);
        check("rst_busy", 8'(pkt_busy), 8'h00);
        rst = 1'b0; we = 1'b0;
        step();
        check("rst_no_write", 8'(empty), 8'h01);

        // Single packet: header 1E (len 7), payload, parity 5C
        pkt[0] = 8'h1E;
        for (int i = 1; i < 8; i++) pkt[i] = 8'h10 + 8'(i);
        pkt[8] = 8'h5C;
        for (int i = 0; i < 9; i++) wr(pkt[i], i == 0);
        check("pkt_not_empty", 8'(empty), 8'h00);
        check("pkt_idle_out", data_out, 8'h00);
        re = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("pkt_rd%0d", i), data_out, pkt[i]);
            check($sformatf("pkt_busy%0d", i), 8'(pkt_busy), (i < 8) ? 8'h01 : 8'h00);
        end
        re = 1'b0;
        step();
        check("pkt_out_zero", data_out, 8'h00);
        check("pkt_empty", 8'(empty), 8'h01);

        // Full boundary
        for (int i = 0; i < 16; i++) begin
            wr(8'h20 + 8'(i), 1'b0);
            check($sformatf("fill_full%0d", i), 8'(full), (i == 15) ? 8'h01 : 8'h00);
        end
        wr(8'hFF, 1'b0);
        check("drop_full", 8'(full), 8'h01);
        re = 1'b1; step(); re = 1'b0;
        check("full_rd0", data_out, 8'h20);
        check("full_cleared", 8'(full), 8'h00);
        wr(8'h30, 1'b0);
        check("refull", 8'(full), 8'h01);
        re = 1'b1;
        for (int i = 1; i < 17; i++) begin
            step();
            check($sformatf("full_rd%0d", i), data_out, (i < 16) ? 8'h20 + 8'(i) : 8'h30);
        end
        re = 1'b0;
        check("full_drained", 8'(empty), 8'h01);

        // Wrap with concurrent read and write, 4 entries occupied
        for (int i = 0; i < 4; i++) wr(8'h40 + 8'(i), 1'b0);
        we = 1'b1; re = 1'b1;
        for (int i = 0; i < 40; i++) begin
            data_in = 8'h44 + 8'(i);
            step();
            check($sformatf("wrap_rd%0d", i), data_out, 8'h40 + 8'(i));
            check($sformatf("wrap_flags%0d", i), {6'd0, full, empty}, 8'h00);
        end
        we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("wrap_drain%0d", i), data_out, 8'h68 + 8'(i));
        end
        re = 1'b0;
        check("wrap_empty", 8'(empty), 8'h01);

        // Soft reset mid-packet
        for (int i = 0; i < 9; i++) wr(pkt[i], i == 0);
        re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("srst_rd%0d", i), data_out, pkt[i]);
        end
        re = 1'b0; soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        check("srst_empty", 8'(empty), 8'h01);
        check("srst_busy", 8'(pkt_busy), 8'h00);
        check("srst_out", data_out, 8'h00);
        wr(8'h04, 1'b1);
        wr(8'h77, 1'b0);
        wr(8'h73, 1'b0);
        re = 1'b1;
        step(); check("p2_hdr", data_out, 8'h04); check("p2_busy0", 8'(pkt_busy), 8'h01);
        step(); check("p2_pay", data_out, 8'h77); check("p2_busy1", 8'(pkt_busy), 8'h01);
        step(); check("p2_par", data_out, 8'h73); check("p2_busy2", 8'(pkt_busy), 8'h00);
        re = 1'b0;
        step(); check("p2_out_zero", data_out, 8'h00);

        // Read while empty is ignored
        re = 1'b1;
        step(); step();
        check("erd_out", data_out, 8'h00);
        check("erd_empty", 8'(empty), 8'h01);
        re = 1'b0;
        wr(8'h99, 1'b0);
        check("erd_one_entry", 8'(empty), 8'h00);
        re = 1'b1; step(); re = 1'b0;
        check("erd_readback", data_out, 8'h99);
        check("erd_empty_after", 8'(empty), 8'h01);

        // Asynchronous reset mid-packet, then a fresh packet
        wr(8'h1E, 1'b1);
        wr(8'h11, 1'b0);
        re = 1'b1; step(); re = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_out", data_out, 8'h00);
        check("arst_empty", 8'(empty), 8'h01);
        check("arst_busy", 8'(pkt_busy), 8'h00);
        step();
        rst = 1'b0;
        wr(8'h00, 1'b1);
        wr(8'hC3, 1'b0);
        re = 1'b1;
        step(); check("arst_hdr", data_out, 8'h00); check("arst_hdr_busy", 8'(pkt_busy), 8'h01);
        step(); check("arst_par", data_out, 8'hC3); check("arst_par_busy", 8'(pkt_busy), 8'h00);
        re = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
